// File: rtl/pcm_pkg.sv
// Shared constants and types for the PCM request path (arbiter, PCM_MM_reg, memory scheduler).
package pcm_pkg;

    localparam int unsigned NUM_CPU = 4;
    localparam int unsigned ADDR_W  = 20;
    localparam int unsigned DATA_W  = 16;

    localparam logic [15:0] ERR_DATA = 16'hDEAD;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/pcm_rr_pick.sv
// Combinational rotate-priority pick: first set bit of req searching upward from last_grant+1.
module pcm_rr_pick #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic          found,
    output logic [IW-1:0] winner
);

    // Scan from the farthest candidate back to the nearest so the nearest one wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = int'(N); k >= 1; k--) begin
            int idx;
            idx = (int'(last_grant) + k) % int'(N);
            if (req[idx]) begin
                found  = 1'b1;
                winner = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/pcm_cpu_arbiter.sv
// Round-robin arbiter serialising per-core PCM read/write requests onto one valid/ready port.
module pcm_cpu_arbiter
    import pcm_pkg::*;
#(
    parameter int unsigned       NUM_CPU  = pcm_pkg::NUM_CPU,
    parameter int unsigned       ADDR_W   = pcm_pkg::ADDR_W,
    parameter int unsigned       DATA_W   = pcm_pkg::DATA_W,
    parameter int unsigned       TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = pcm_pkg::ERR_DATA
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CPU-1:0]          cpu_req,
    input  logic [NUM_CPU-1:0]          cpu_write,
    input  logic [NUM_CPU*ADDR_W-1:0]   cpu_addr,
    input  logic [NUM_CPU*DATA_W-1:0]   cpu_data_in,
    output logic [NUM_CPU-1:0]          cpu_ready,
    output logic [NUM_CPU*DATA_W-1:0]   cpu_data_out,
    output logic                        mm_valid,
    output logic                        mm_write,
    output logic [ADDR_W-1:0]           mm_addr,
    output logic [DATA_W-1:0]           mm_wdata,
    input  logic                        mm_ready,
    input  logic [DATA_W-1:0]           mm_rdata,
    output logic [$clog2(NUM_CPU)-1:0]  grant_id,
    output logic                        err_timeout
);

    localparam int unsigned GW = $clog2(NUM_CPU);
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    arb_state_t    state_q;
    logic [GW-1:0] last_grant_q;
    logic [WW-1:0] wd_q;
    logic          found;
    logic [GW-1:0] winner;
    logic          wd_hit;

    pcm_rr_pick #(
        .N(NUM_CPU)
    ) u_pick (
        .req       (cpu_req),
        .last_grant(last_grant_q),
        .found     (found),
        .winner    (winner)
    );

    assign wd_hit = (wd_q == WW'(TIMEOUT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= GW'(NUM_CPU - 1);
            wd_q         <= '0;
            mm_valid     <= 1'b0;
            mm_write     <= 1'b0;
            mm_addr      <= '0;
            mm_wdata     <= '0;
            cpu_ready    <= '0;
            cpu_data_out <= '0;
            grant_id     <= '0;
            err_timeout  <= 1'b0;
        end else begin
            cpu_ready <= '0;
            unique case (state_q)
                IDLE: begin
                    if (found) begin
                        grant_id <= winner;
                        mm_write <= cpu_write[winner];
                        mm_addr  <= cpu_addr[int'(winner)*ADDR_W +: ADDR_W];
                        mm_wdata <= cpu_data_in[int'(winner)*DATA_W +: DATA_W];
                        mm_valid <= 1'b1;
                        wd_q     <= '0;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    wd_q <= wd_q + 1'b1;
                    // A completion on the timeout cycle still counts as a normal completion.
                    if (mm_ready || wd_hit) begin
                        mm_valid            <= 1'b0;
                        cpu_ready[grant_id] <= 1'b1;
                        cpu_data_out[int'(grant_id)*DATA_W +: DATA_W] <=
                            mm_ready ? mm_rdata : ERR_DATA;
                        if (!mm_ready) begin
                            err_timeout <= 1'b1;
                        end
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    last_grant_q <= grant_id;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pcm_cpu_arbiter.sv
// Self-checking bench: directed literal cases plus randomized traffic against a transaction-level model.
module tb_pcm_cpu_arbiter;

    localparam int N  = 4;
    localparam int AW = 20;
    localparam int DW = 16;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      cpu_req;
    logic [N-1:0]      cpu_write;
    logic [N*AW-1:0]   cpu_addr;
    logic [N*DW-1:0]   cpu_data_in;
    logic [N-1:0]      cpu_ready;
    logic [N*DW-1:0]   cpu_data_out;
    logic              mm_valid;
    logic              mm_write;
    logic [AW-1:0]     mm_addr;
    logic [DW-1:0]     mm_wdata;
    logic              mm_ready;
    logic [DW-1:0]     mm_rdata;
    logic [1:0]        grant_id;
    logic              err_timeout;

    pcm_cpu_arbiter #(
        .NUM_CPU (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO),
        .ERR_DATA(16'hDEAD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_write   (cpu_write),
        .cpu_addr    (cpu_addr),
        .cpu_data_in (cpu_data_in),
        .cpu_ready   (cpu_ready),
        .cpu_data_out(cpu_data_out),
        .mm_valid    (mm_valid),
        .mm_write    (mm_write),
        .mm_addr     (mm_addr),
        .mm_wdata    (mm_wdata),
        .mm_ready    (mm_ready),
        .mm_rdata    (mm_rdata),
        .grant_id    (grant_id),
        .err_timeout (err_timeout)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model: one outstanding transfer, nearest requester after the last grant.
    function automatic int pick(input logic [N-1:0] req, input int last);
        for (int k = 1; k <= N; k++) begin
            int c = (last + k) % N;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    bit            m_busy, m_done, m_err, m_write;
    int            m_age, m_gid, m_last;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_data [N];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_err   <= 1'b0;
            m_age   <= 0;
            m_gid   <= 0;
            m_last  <= N - 1;
            m_write <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            for (int i = 0; i < N; i++) m_data[i] <= '0;
        end else if (m_done) begin
            m_done <= 1'b0;
            m_last <= m_gid;
        end else if (m_busy) begin
            m_age <= m_age + 1;
            if (mm_ready) begin
                m_data[m_gid] <= mm_rdata;
                m_busy        <= 1'b0;
                m_done        <= 1'b1;
            end else if (m_age + 1 > TO) begin
                // abort once the transfer has been outstanding for TIMEOUT+1 cycles
                m_data[m_gid] <= 16'hDEAD;
                m_err         <= 1'b1;
                m_busy        <= 1'b0;
                m_done        <= 1'b1;
            end
        end else if (pick(cpu_req, m_last) >= 0) begin
            m_gid   <= pick(cpu_req, m_last);
            m_busy  <= 1'b1;
            m_age   <= 0;
            m_write <= cpu_write[pick(cpu_req, m_last)];
            m_addr  <= cpu_addr[pick(cpu_req, m_last)*AW +: AW];
            m_wdata <= cpu_data_in[pick(cpu_req, m_last)*DW +: DW];
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("mm_valid", 32'(mm_valid), 32'(m_busy));
                chk("mm_write", 32'(mm_write), 32'(m_write));
                chk("mm_addr", 32'(mm_addr), 32'(m_addr));
                chk("mm_wdata", 32'(mm_wdata), 32'(m_wdata));
                chk("grant_id", 32'(grant_id), 32'(m_gid));
                chk("err_timeout", 32'(err_timeout), 32'(m_err));
                chk("cpu_ready", 32'(cpu_ready), m_done ? (32'd1 << m_gid) : 32'd0);
                for (int i = 0; i < N; i++)
                    chk($sformatf("cpu_data_out[%0d]", i), 32'(cpu_data_out[i*DW +: DW]),
                        32'(m_data[i]));
            end
        end
    end

    // Downstream responder: fixed or random latency, optional spurious pulses while idle.
    int            resp_lat  = -1;
    bit            resp_rand = 1'b0;
    bit            spur_en   = 1'b0;
    logic [DW-1:0] resp_data = '0;

    initial begin : responder
        int cnt, target;
        cnt      = 0;
        target   = -1;
        mm_ready = 1'b0;
        mm_rdata = '0;
        forever begin
            @(negedge clk);
            mm_ready = 1'b0;
            mm_rdata = DW'($urandom);
            if (mm_valid && !reset) begin
                cnt++;
                if (cnt == 1) target = resp_rand ? int'($urandom_range(1, 11)) : resp_lat;
                if (cnt == target) begin
                    mm_ready = 1'b1;
                    mm_rdata = resp_rand ? DW'($urandom) : resp_data;
                end
            end else begin
                cnt = 0;
                if (spur_en && $urandom_range(0, 3) == 0) mm_ready = 1'b1;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        cpu_req = '0;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic wait_valid(output int t);
        t = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (mm_valid) begin
                t = cyc;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL wait_mm_valid: no mm_valid within 50 cycles");
    endtask

    task automatic wait_ready(input int i, output int t);
        t = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (cpu_ready[i]) begin
                t = cyc;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL wait_cpu_ready%0d: no pulse within 50 cycles", i);
    endtask

    task automatic set_core(input int i, input bit wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
        cpu_write[i]             = wr;
        cpu_addr[i*AW +: AW]     = a;
        cpu_data_in[i*DW +: DW]  = d;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "simulation time limit");
    end

    initial begin : main
        int tv, tr, prev;
        reset       = 1'b1;
        cpu_req     = '0;
        cpu_write   = '0;
        cpu_addr    = '0;
        cpu_data_in = '0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;

        // reset values
        @(negedge clk);
        chk("rst mm_valid", 32'(mm_valid), 32'd0);
        chk("rst mm_addr", 32'(mm_addr), 32'd0);
        chk("rst grant_id", 32'(grant_id), 32'd0);
        chk("rst err_timeout", 32'(err_timeout), 32'd0);
        chk("rst cpu_ready", 32'(cpu_ready), 32'd0);
        chk("rst cpu_data_out", 32'(cpu_data_out[31:0]), 32'd0);

        // single read on cpu1, mm_ready four cycles after mm_valid
        resp_rand = 1'b0;
        resp_lat  = 4;
        resp_data = 16'h0FF0;
        set_core(1, 1'b0, 20'hFFFFF, 16'h0000);
        cpu_req[1] = 1'b1;
        wait_valid(tv);
        chk("rd mm_addr", 32'(mm_addr), 32'h000FFFFF);
        chk("rd mm_write", 32'(mm_write), 32'd0);
        chk("rd grant_id", 32'(grant_id), 32'd1);
        wait_ready(1, tr);
        chk("rd latency", 32'(tr - tv), 32'd4);
        chk("rd cpu_ready", 32'(cpu_ready), 32'h2);
        chk("rd data1", 32'(cpu_data_out[1*DW +: DW]), 32'h0FF0);
        chk("rd data0", 32'(cpu_data_out[0*DW +: DW]), 32'd0);
        chk("rd data2", 32'(cpu_data_out[2*DW +: DW]), 32'd0);
        chk("rd data3", 32'(cpu_data_out[3*DW +: DW]), 32'd0);
        cpu_req[1] = 1'b0;
        @(negedge clk);
        chk("rd pulse width", 32'(cpu_ready), 32'd0);

        // write on cpu0, immediate mm_ready
        resp_lat = 1;
        set_core(0, 1'b1, 20'h00010, 16'h1234);
        cpu_req[0] = 1'b1;
        wait_valid(tv);
        chk("wr mm_write", 32'(mm_write), 32'd1);
        chk("wr mm_wdata", 32'(mm_wdata), 32'h1234);
        chk("wr mm_addr", 32'(mm_addr), 32'h00010);
        chk("wr grant_id", 32'(grant_id), 32'd0);
        wait_ready(0, tr);
        chk("wr latency", 32'(tr - tv), 32'd1);
        cpu_req[0] = 1'b0;

        // fairness with all cores requesting continuously
        do_reset();
        resp_lat = 1;
        for (int i = 0; i < N; i++) set_core(i, 1'b0, AW'(i * 16 + 5), DW'(i));
        cpu_req = '1;
        prev    = 0;
        for (int g = 0; g < 6; g++) begin
            wait_valid(tv);
            chk($sformatf("fair grant%0d", g), 32'(grant_id), 32'(g % N));
            if (g > 0) chk($sformatf("fair spacing%0d", g), 32'(tv - prev), 32'd3);
            prev = tv;
            for (int k = 0; k < 20 && mm_valid; k++) @(negedge clk);
        end
        cpu_req = '0;
        repeat (6) @(negedge clk);

        // mm_ready on the timeout cycle is a normal completion
        do_reset();
        resp_lat  = TO + 1;
        resp_data = 16'h5A5A;
        set_core(3, 1'b0, 20'h0ABCD, 16'h0000);
        cpu_req[3] = 1'b1;
        wait_valid(tv);
        wait_ready(3, tr);
        chk("edge latency", 32'(tr - tv), 32'(TO + 1));
        chk("edge data", 32'(cpu_data_out[3*DW +: DW]), 32'h5A5A);
        chk("edge err_timeout", 32'(err_timeout), 32'd0);
        cpu_req[3] = 1'b0;

        // timeout, with cpu2 fields changing mid-transfer
        resp_lat = -1;
        set_core(2, 1'b0, 20'h12345, 16'h0000);
        cpu_req[2] = 1'b1;
        wait_valid(tv);
        chk("to mm_addr", 32'(mm_addr), 32'h12345);
        set_core(2, 1'b1, 20'h54321, 16'hBEEF);
        @(negedge clk);
        chk("stable mm_addr", 32'(mm_addr), 32'h12345);
        chk("stable mm_write", 32'(mm_write), 32'd0);
        wait_ready(2, tr);
        chk("to latency", 32'(tr - tv), 32'(TO + 1));
        chk("to data", 32'(cpu_data_out[2*DW +: DW]), 32'hDEAD);
        chk("to err_timeout", 32'(err_timeout), 32'd1);
        cpu_req[2] = 1'b0;
        repeat (5) @(negedge clk);
        chk("to err sticky", 32'(err_timeout), 32'd1);

        // spurious mm_ready while idle
        spur_en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("spur cpu_ready", 32'(cpu_ready), 32'd0);
        end
        spur_en = 1'b0;

        // reset in the middle of a transfer
        set_core(2, 1'b0, 20'h00777, 16'h0000);
        cpu_req[2] = 1'b1;
        wait_valid(tv);
        @(negedge clk);
        #2 reset = 1'b1;
        cpu_req = '0;
        #1;
        chk("midrst mm_valid", 32'(mm_valid), 32'd0);
        chk("midrst cpu_ready", 32'(cpu_ready), 32'd0);
        chk("midrst err_timeout", 32'(err_timeout), 32'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("midrst no pulse", 32'(cpu_ready), 32'd0);
        end
        resp_lat = 2;
        set_core(0, 1'b0, 20'h00001, 16'h0000);
        cpu_req[0] = 1'b1;
        cpu_req[2] = 1'b1;
        wait_valid(tv);
        chk("midrst next grant", 32'(grant_id), 32'd0);
        wait_ready(0, tr);
        cpu_req[0] = 1'b0;
        wait_ready(2, tr);
        cpu_req[2] = 1'b0;

        // randomized traffic
        do_reset();
        resp_rand = 1'b1;
        spur_en   = 1'b1;
        for (int it = 0; it < 4000; it++) begin
            if (it == 2000) do_reset();
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!cpu_req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        set_core(i, 1'($urandom), AW'($urandom), DW'($urandom));
                        cpu_req[i] = 1'b1;
                    end
                end else if (cpu_ready[i]) begin
                    cpu_req[i] = 1'b0;
                end else begin
                    int r = int'($urandom_range(0, 99));
                    if (r < 2) cpu_req[i] = 1'b0;
                    else if (r < 10) cpu_addr[i*AW +: AW] = AW'($urandom);
                end
            end
        end
        cpu_req = '0;
        spur_en = 1'b0;
        repeat (20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
